// File: rtl/valid_train_pkg.sv
// Shared constants and types for valid-lane training (RX detector and TX controller).
// Optional feature macro used by consumers: VALID_DET_ROTATION_EN.
package valid_train_pkg;

    // Per-byte valid-lane training pattern and its 32-bit replicated word
    localparam logic [7:0]  VALID_8BIT         = 8'h0F;
    localparam logic [31:0] VALID_WORD_DEFAULT = {4{VALID_8BIT}};

    // Width of word / run / error counters (window is at most 63 words)
    localparam int CNT_W = 6;
    localparam int ROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_DONE   = 2'd3
    } vd_state_t;

    // Rotate a pattern byte left by idx and replicate it across a 32-bit word
    function automatic logic [31:0] rot_word(input logic [7:0] b, input logic [ROT_W-1:0] idx);
        logic [15:0] dbl;
        dbl = {b, b} << idx;
        return {4{dbl[15:8]}};
    endfunction

endpackage

// File: rtl/valid_word_matcher.sv
// Combinational comparison of one received valid-lane word against the training pattern.
// With VALID_DET_ROTATION_EN any bit-rotation of the pattern byte matches until a
// rotation is locked; without it only the exact pattern word matches.
module valid_word_matcher
    import valid_train_pkg::*;
#(
    parameter logic [31:0] PATTERN_WORD = VALID_WORD_DEFAULT
) (
    input  logic [31:0]      word,
`ifdef VALID_DET_ROTATION_EN
    input  logic             locked,
    input  logic [ROT_W-1:0] lock_idx,
    output logic [ROT_W-1:0] rot_idx,
`endif
    output logic             match
);

`ifdef VALID_DET_ROTATION_EN
    // Locked: compare only the locked rotation; unlocked: lowest matching rotation wins
    always_comb begin
        match   = 1'b0;
        rot_idx = '0;
        if (locked) begin
            match   = (word == rot_word(PATTERN_WORD[7:0], lock_idx));
            rot_idx = lock_idx;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (word == rot_word(PATTERN_WORD[7:0], ROT_W'(i))) begin
                    match   = 1'b1;
                    rot_idx = ROT_W'(i);
                end
            end
        end
    end
`else
    // Exact comparison against the configured pattern word
    always_comb begin
        match = (word == PATTERN_WORD);
    end
`endif

endmodule

// File: rtl/valid_pattern_detector.sv
// Valid-lane training detector: evaluates a window of received words, tracks the
// longest run of matching words and reports pass/fail once the window completes.
// Optional feature macro: VALID_DET_ROTATION_EN (accept any rotation of the pattern byte).
// Handshake: i_enable_detector high = a word is presented every cycle (no backpressure);
// o_done stays high until i_enable_detector falls, which returns the block to IDLE.
module valid_pattern_detector
    import valid_train_pkg::*;
#(
    parameter logic [31:0] PATTERN_WORD  = VALID_WORD_DEFAULT,
    parameter int          WINDOW_WORDS  = 32,
    parameter int          CONSEC_THRESH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable_detector,
    input  logic [31:0]      i_rvld_l,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_max_consec,
    output vd_state_t        o_dbg_state
);

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_WORDS);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(CONSEC_THRESH);

    vd_state_t        state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             match;
    logic             sample;
    logic             window_end;

`ifdef VALID_DET_ROTATION_EN
    logic [ROT_W-1:0] lock_idx_q, lock_idx_d, rot_idx;

    valid_word_matcher #(.PATTERN_WORD(PATTERN_WORD)) u_matcher (
        .word     (i_rvld_l),
        .locked   (state_q == ST_TRACK),
        .lock_idx (lock_idx_q),
        .rot_idx  (rot_idx),
        .match    (match)
    );
`else
    valid_word_matcher #(.PATTERN_WORD(PATTERN_WORD)) u_matcher (
        .word  (i_rvld_l),
        .match (match)
    );
`endif

    // A word is evaluated on every enabled cycle outside DONE; flag the window's last word
    always_comb begin
        sample       = i_enable_detector && (state_q != ST_DONE);
        word_cnt_inc = word_cnt_q + CNT_W'(1);
        window_end   = sample && (word_cnt_inc == WIN_LAST);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; dropping the enable always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_SEARCH: begin
                if (!i_enable_detector) state_d = ST_IDLE;
                else if (window_end)    state_d = ST_DONE;
                else if (match)         state_d = ST_TRACK;
                else                    state_d = ST_SEARCH;
            end
            ST_TRACK: begin
                if (!i_enable_detector) state_d = ST_IDLE;
                else if (window_end)    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!i_enable_detector) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter / result updates for the evaluated word; cleared whenever the enable is low
    always_comb begin
        word_cnt_d = word_cnt_q;
        consec_d   = consec_q;
        max_d      = max_q;
        err_d      = err_q;
        pass_d     = pass_q;
`ifdef VALID_DET_ROTATION_EN
        lock_idx_d = lock_idx_q;
`endif
        if (!i_enable_detector) begin
            word_cnt_d = '0;
            consec_d   = '0;
            max_d      = '0;
            err_d      = '0;
            pass_d     = 1'b0;
`ifdef VALID_DET_ROTATION_EN
            lock_idx_d = '0;
`endif
        end else if (sample) begin
            word_cnt_d = word_cnt_inc;
            if (state_q == ST_TRACK) begin
                if (match) begin
                    consec_d = consec_q + CNT_W'(1);
                end else begin
                    consec_d = '0;
                    if (err_q != '1) err_d = err_q + CNT_W'(1);
                end
            end else if (match) begin
                consec_d = CNT_W'(1);
`ifdef VALID_DET_ROTATION_EN
                lock_idx_d = rot_idx;
`endif
            end
            if (consec_d > max_q) max_d = consec_d;
            if (window_end) pass_d = (max_d >= THRESH);
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_cnt_q <= '0;
            consec_q   <= '0;
            max_q      <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
`ifdef VALID_DET_ROTATION_EN
            lock_idx_q <= '0;
`endif
        end else begin
            word_cnt_q <= word_cnt_d;
            consec_q   <= consec_d;
            max_q      <= max_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
`ifdef VALID_DET_ROTATION_EN
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    // Outputs decoded from state and registered results
    always_comb begin
        o_done       = (state_q == ST_DONE);
        o_busy       = (state_q == ST_SEARCH) || (state_q == ST_TRACK);
        o_pass       = pass_q;
        o_err_count  = err_q;
        o_max_consec = max_q;
        o_dbg_state  = state_q;
    end

endmodule

// File: doc/valid_pattern_detector.md
VALID_PATTERN_DETECTOR -- requirements
Module: valid_pattern_detector

Interface
REQ-001 SHALL have parameter PATTERN_WORD, default 32'h0F0F0F0F, meaning the expected 32-bit valid-lane word (8-bit 00001111 replicated 4x).
REQ-002 SHALL have parameter WINDOW_WORDS, default 32, meaning the number of words evaluated per training run (range 1..63).
REQ-003 SHALL have parameter CONSEC_THRESH, default 16, meaning the consecutive matching words required for pass (range 1..WINDOW_WORDS).
REQ-004 SHALL have port i_clk, input, 1, the single clock for all state.
REQ-005 SHALL have port i_rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port i_enable_detector, input, 1, high while the far-end transmitter drives the valid pattern.
REQ-007 SHALL have port i_rvld_l, input, 32, the received valid-lane word, sampled every cycle i_enable_detector is high.
REQ-008 SHALL have port o_done, output, 1, high when the window completes; held until i_enable_detector falls.
REQ-009 SHALL have port o_pass, output, 1, the training result, meaningful only while o_done is high.
REQ-010 SHALL have port o_busy, output, 1, high in SEARCH or TRACK.
REQ-011 SHALL have port o_err_count, output, 6, mismatching words seen in TRACK, saturating at 63.
REQ-012 SHALL have port o_max_consec, output, 6, the longest run of consecutive matching words in the current run.

Function
REQ-013 SHALL implement the states IDLE, SEARCH, TRACK and DONE.
REQ-014 Sampling: a word SHALL be evaluated on every rising edge with i_enable_detector=1 and state in {IDLE, SEARCH, TRACK}; the word present with the enable's first high cycle is word 0 (zero-bubble, matching a transmitter that registers data and enable together).
REQ-015 IDLE SHALL go to SEARCH on the first sampled word, or directly to TRACK if that word matches.
REQ-016 A SEARCH match SHALL lock the rotation, set consec=1 and go to TRACK; a mismatch SHALL stay in SEARCH without incrementing the error count.
REQ-017 In TRACK, a match on the locked rotation SHALL increment consec; a mismatch SHALL clear consec to 0 and increment err_count, saturating at 63.
REQ-018 max_consec SHALL update to consec on the same edge whenever consec exceeds it.
REQ-019 word_cnt (6-bit) SHALL count evaluated words; on the edge the WINDOW_WORDS-th word is evaluated, state SHALL go to DONE with o_done=1 visible the next cycle and o_pass=(updated max_consec >= CONSEC_THRESH).
REQ-020 A window ending in SEARCH SHALL give o_pass=0.
REQ-021 DONE SHALL ignore i_rvld_l and hold all outputs until i_enable_detector=0, then go to IDLE clearing o_done, o_pass, counters and lock.
REQ-022 i_enable_detector falling in SEARCH or TRACK (abort) SHALL return to IDLE next edge with all outputs cleared and no o_done pulse.
REQ-023 i_enable_detector re-rising after IDLE SHALL start a fresh run; no state from the prior run is retained.

Reset
REQ-024 When i_rst=1 at a rising edge, state SHALL be IDLE and o_done, o_pass, o_busy, o_err_count, o_max_consec, consec, word_cnt and the rotation lock SHALL be 0.
REQ-025 i_rst SHALL take priority over i_enable_detector, including mid-run.

Configuration
REQ-026 With VALID_DET_ROTATION_EN defined, a match SHALL be any of the 8 bit-rotations of PATTERN_WORD[7:0] replicated 4x; SEARCH locks the first matching rotation (lowest index wins) and TRACK compares only against that rotation.
REQ-027 Without VALID_DET_ROTATION_EN, a match SHALL be i_rvld_l == PATTERN_WORD exactly, with no rotation lock logic present.

Structure
REQ-028 Shared package valid_train_pkg SHALL hold VALID_8BIT, the default pattern word, the state enum and the counter width constant; the TX controller SHALL reuse the same constants.
REQ-029 The block SHALL use one combinational sub-module, valid_word_matcher, taking the word (plus locked index) and returning match and rotation index.

Verification
REQ-030 Enable high 32 cycles with 32'h0F0F0F0F every cycle: o_done=1 on cycle 33, o_pass=1, o_max_consec=32, o_err_count=0.
REQ-031 Same run with 32'hFFFFFFFF on words 10 and 20: o_err_count=2, o_max_consec=11, o_pass=0.
REQ-032 Words 0-3 = 0 then 28 good words: 4 cycles in SEARCH, o_err_count=0, o_max_consec=28, o_pass=1.
REQ-033 With the macro defined and words = 32'h87878787: lock on rotation, o_pass=1; without the macro, o_pass=0.
REQ-034 Enable drops after word 15: IDLE next cycle, o_done never asserts; a subsequent clean run passes.
REQ-035 i_rst=1 at word 20 with enable held: all outputs 0 next cycle; run restarts from word 0 after release.
